// File: rtl/obi_ibus_dbus_arbiter.sv
// obi_ibus_dbus_arbiter: shares one OBI master port between the core's instruction and data ports,
// keeping an in-order ID FIFO so each response returns to the port that issued it.
module obi_ibus_dbus_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter bit ROUND_ROBIN     = 1'b1
) (
  input  logic        hclk_i,
  input  logic        hreset_i,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        m_req_o,
  input  logic        m_gnt_i,
  output logic        m_we_o,
  output logic [3:0]  m_be_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  input  logic        m_rvalid_i,
  input  logic [31:0] m_rdata_i,
  input  logic        m_err_i,
  output logic        m_busy_o,
  output logic        proto_err_o
);
  typedef enum logic {INSTR = 1'b0, DATA = 1'b1} port_e;
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [2:0] DEPTH = 3'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST = PW'(MAX_OUTSTANDING - 1);

  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0] count_q, count_d;
  port_e last_q, last_d, locked_sel_q, locked_sel_d, winner, head;
  logic lock_q, lock_d, proto_err_q, proto_err_d;
  logic act, empty, can_issue, win_req, push, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == LAST ? '0 : p + 1'b1;
  endfunction

  // Outputs are held quiet while reset is asserted, except the rdata pass-through
  assign act       = ~hreset_i;
  assign empty     = count_q == 3'd0;
  assign can_issue = (count_q < DEPTH) || m_rvalid_i;
  assign winner    = lock_q ? locked_sel_q :
                     (instr_req_i && data_req_i) ? (ROUND_ROBIN ? (last_q == INSTR ? DATA : INSTR) : DATA) :
                     (data_req_i ? DATA : INSTR);
  assign win_req   = winner == DATA ? data_req_i : instr_req_i;
  assign head      = port_e'(fifo_q[rd_ptr_q]);

  assign m_req_o   = act && can_issue && win_req;
  assign m_we_o    = act && winner == DATA && data_we_i;
  assign m_be_o    = !act ? 4'h0 : winner == DATA ? data_be_i : 4'hF;
  assign m_addr_o  = !act ? 32'h0 : winner == DATA ? data_addr_i : instr_addr_i;
  assign m_wdata_o = (act && winner == DATA) ? data_wdata_i : 32'h0;
  assign push      = m_req_o && m_gnt_i;
  assign pop       = act && m_rvalid_i && !empty;

  assign instr_gnt_o    = push && winner == INSTR;
  assign data_gnt_o     = push && winner == DATA;
  assign instr_rvalid_o = pop && head == INSTR;
  assign data_rvalid_o  = pop && head == DATA;
  assign instr_err_o    = instr_rvalid_o && m_err_i;
  assign data_err_o     = data_rvalid_o && m_err_i;
  assign instr_rdata_o  = m_rdata_i;
  assign data_rdata_o   = m_rdata_i;
  assign m_busy_o       = act && count_q == DEPTH;
  assign proto_err_o    = proto_err_q;

  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = winner;
  end

  assign wr_ptr_d     = push ? nxt(wr_ptr_q) : wr_ptr_q;
  assign rd_ptr_d     = pop ? nxt(rd_ptr_q) : rd_ptr_q;
  assign count_d      = count_q + {2'b0, push} - {2'b0, pop};
  assign last_d       = push ? winner : last_q;
  // Hold the address phase on the current winner until the adapter grants it
  assign lock_d       = m_req_o && !m_gnt_i;
  assign locked_sel_d = winner;
  assign proto_err_d  = proto_err_q || (m_rvalid_i && empty);

  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) begin
      fifo_q       <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= 3'd0;
      last_q       <= INSTR;
      locked_sel_q <= INSTR;
      lock_q       <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      fifo_q       <= fifo_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      last_q       <= last_d;
      locked_sel_q <= locked_sel_d;
      lock_q       <= lock_d;
      proto_err_q  <= proto_err_d;
    end
  end
endmodule

// File: tb/tb_obi_ibus_dbus_arbiter.sv
// tb_obi_ibus_dbus_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_obi_ibus_dbus_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic ir, dr, dwe, mg, mv, me;
  logic [3:0] dbe;
  logic [31:0] ia, da, dwd, mrd;
  logic igt, irv, ierr, dgt, drv, derr, mreq, mwe, busy, perr;
  logic [3:0] mbe;
  logic [31:0] ird, drd, maddr, mwd;
  logic fp_igt, fp_irv, fp_ierr, fp_dgt, fp_drv, fp_derr, fp_mreq, fp_mwe, fp_busy, fp_perr;
  logic [3:0] fp_mbe;
  logic [31:0] fp_ird, fp_drd, fp_maddr, fp_mwd;
  int errs = 0, checks = 0;

  obi_ibus_dbus_arbiter #(.MAX_OUTSTANDING(2), .ROUND_ROBIN(1'b1)) dut (
    .hclk_i(clk), .hreset_i(rst),
    .instr_req_i(ir), .instr_gnt_o(igt), .instr_addr_i(ia), .instr_rvalid_o(irv),
    .instr_rdata_o(ird), .instr_err_o(ierr),
    .data_req_i(dr), .data_gnt_o(dgt), .data_we_i(dwe), .data_be_i(dbe), .data_addr_i(da),
    .data_wdata_i(dwd), .data_rvalid_o(drv), .data_rdata_o(drd), .data_err_o(derr),
    .m_req_o(mreq), .m_gnt_i(mg), .m_we_o(mwe), .m_be_o(mbe), .m_addr_o(maddr), .m_wdata_o(mwd),
    .m_rvalid_i(mv), .m_rdata_i(mrd), .m_err_i(me), .m_busy_o(busy), .proto_err_o(perr)
  );

  obi_ibus_dbus_arbiter #(.MAX_OUTSTANDING(2), .ROUND_ROBIN(1'b0)) u_fp (
    .hclk_i(clk), .hreset_i(rst),
    .instr_req_i(ir), .instr_gnt_o(fp_igt), .instr_addr_i(ia), .instr_rvalid_o(fp_irv),
    .instr_rdata_o(fp_ird), .instr_err_o(fp_ierr),
    .data_req_i(dr), .data_gnt_o(fp_dgt), .data_we_i(dwe), .data_be_i(dbe), .data_addr_i(da),
    .data_wdata_i(dwd), .data_rvalid_o(fp_drv), .data_rdata_o(fp_drd), .data_err_o(fp_derr),
    .m_req_o(fp_mreq), .m_gnt_i(mg), .m_we_o(fp_mwe), .m_be_o(fp_mbe), .m_addr_o(fp_maddr), .m_wdata_o(fp_mwd),
    .m_rvalid_i(mv), .m_rdata_i(mrd), .m_err_i(me), .m_busy_o(fp_busy), .proto_err_o(fp_perr)
  );

  task automatic idle;
    ir = 0; dr = 0; dwe = 0; mg = 0; mv = 0; me = 0;
    dbe = 4'h0; ia = 32'h0; da = 32'h0; dwd = 32'h0; mrd = 32'h0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset;
    idle();
    rst = 1;
    ir = 1; dr = 1; mg = 1; mv = 1; mrd = 32'hCAFE_BABE;
    @(negedge clk);
    checks++; if (mreq !== 1'b0 || igt !== 1'b0 || dgt !== 1'b0) begin errs++; $display("FAIL reset_req req=%b igt=%b dgt=%b exp 0", mreq, igt, dgt); end
    checks++; if (irv !== 1'b0 || drv !== 1'b0 || busy !== 1'b0 || perr !== 1'b0) begin errs++; $display("FAIL reset_flags irv=%b drv=%b busy=%b perr=%b exp 0", irv, drv, busy, perr); end
    checks++; if (ird !== 32'hCAFE_BABE || drd !== 32'hCAFE_BABE) begin errs++; $display("FAIL reset_rdata got %h/%h exp cafebabe", ird, drd); end
    idle();
    @(negedge clk);
    rst = 0;
    tick();
  endtask

  task automatic test_instr_single;
    pulse_reset();
    ir = 1; ia = 32'h0000_0080; mg = 1;
    @(negedge clk);
    checks++; if (igt !== 1'b1 || dgt !== 1'b0) begin errs++; $display("FAIL single_gnt igt=%b dgt=%b exp 1/0", igt, dgt); end
    checks++; if (maddr !== 32'h80 || mwe !== 1'b0 || mbe !== 4'hF || mwd !== 32'h0) begin errs++; $display("FAIL single_addr addr=%h we=%b be=%h wd=%h exp 80/0/f/0", maddr, mwe, mbe, mwd); end
    tick();
    ir = 0; mg = 0; mv = 1; mrd = 32'h1234_5678;
    @(negedge clk);
    checks++; if (irv !== 1'b1 || ird !== 32'h1234_5678 || drv !== 1'b0) begin errs++; $display("FAIL single_resp irv=%b rd=%h drv=%b exp 1/12345678/0", irv, ird, drv); end
    tick();
    idle();
  endtask

  task automatic test_rr_alternate;
    pulse_reset();
    ir = 1; dr = 1; mg = 1; ia = 32'h100; da = 32'h200;
    for (int i = 0; i < 4; i++) begin
      mv = (i > 0);
      @(negedge clk);
      checks++; if (dgt !== (i % 2 == 0) || igt !== (i % 2 == 1)) begin errs++; $display("FAIL rr_gnt[%0d] dgt=%b igt=%b exp %b/%b", i, dgt, igt, i % 2 == 0, i % 2 == 1); end
      checks++; if (fp_dgt !== 1'b1 || fp_igt !== 1'b0) begin errs++; $display("FAIL fp_gnt[%0d] dgt=%b igt=%b exp 1/0", i, fp_dgt, fp_igt); end
      tick();
    end
    idle();
  endtask

  task automatic test_lock;
    pulse_reset();
    dr = 1; mg = 1; da = 32'h300;
    tick();
    dr = 0; mg = 0; mv = 1;
    tick();
    mv = 0; dr = 1; dwe = 1; da = 32'h2000_0004; dbe = 4'b0011; dwd = 32'hA5A5_0001; ia = 32'h400;
    for (int i = 0; i < 4; i++) begin
      mg = (i == 3); ir = (i >= 1);
      @(negedge clk);
      checks++; if (maddr !== 32'h2000_0004 || mbe !== 4'b0011 || mwe !== 1'b1 || mreq !== 1'b1) begin errs++; $display("FAIL lock_addr[%0d] addr=%h be=%b we=%b req=%b exp 20000004/0011/1/1", i, maddr, mbe, mwe, mreq); end
      checks++; if (igt !== 1'b0 || dgt !== (i == 3)) begin errs++; $display("FAIL lock_gnt[%0d] igt=%b dgt=%b exp 0/%b", i, igt, dgt, i == 3); end
      tick();
    end
    dr = 0; dwe = 0;
    @(negedge clk);
    checks++; if (igt !== 1'b1 || maddr !== 32'h400) begin errs++; $display("FAIL lock_after igt=%b addr=%h exp 1/400", igt, maddr); end
    tick();
    idle();
  endtask

  task automatic test_capacity;
    pulse_reset();
    dr = 1; mg = 1; da = 32'h500;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (dgt !== 1'b1) begin errs++; $display("FAIL cap_fill[%0d] dgt=%b exp 1", i, dgt); end
      tick();
    end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || mreq !== 1'b0 || dgt !== 1'b0) begin errs++; $display("FAIL cap_full busy=%b req=%b dgt=%b exp 1/0/0", busy, mreq, dgt); end
    mv = 1; mrd = 32'h0BAD_F00D;
    @(negedge clk);
    checks++; if (mreq !== 1'b1 || dgt !== 1'b1 || drv !== 1'b1) begin errs++; $display("FAIL cap_swap req=%b dgt=%b drv=%b exp 1/1/1", mreq, dgt, drv); end
    tick();
    mv = 0; dr = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL cap_count busy=%b exp 1", busy); end
    tick();
    idle();
  endtask

  task automatic test_err_routing;
    pulse_reset();
    dr = 1; mg = 1; da = 32'h600;
    tick();
    dr = 0; ir = 1; ia = 32'h700;
    @(negedge clk);
    checks++; if (igt !== 1'b1) begin errs++; $display("FAIL err_issue igt=%b exp 1", igt); end
    tick();
    idle();
    mv = 1; me = 1; mrd = 32'h1111_2222;
    @(negedge clk);
    checks++; if (drv !== 1'b1 || derr !== 1'b1 || irv !== 1'b0 || ierr !== 1'b0) begin errs++; $display("FAIL err_first drv=%b derr=%b irv=%b ierr=%b exp 1/1/0/0", drv, derr, irv, ierr); end
    tick();
    me = 0;
    @(negedge clk);
    checks++; if (irv !== 1'b1 || ierr !== 1'b0 || drv !== 1'b0 || derr !== 1'b0) begin errs++; $display("FAIL err_second irv=%b ierr=%b drv=%b derr=%b exp 1/0/0/0", irv, ierr, drv, derr); end
    tick();
    idle();
  endtask

  task automatic test_proto_err_and_reset;
    pulse_reset();
    mv = 1;
    @(negedge clk);
    checks++; if (irv !== 1'b0 || drv !== 1'b0 || perr !== 1'b0) begin errs++; $display("FAIL proto_drop irv=%b drv=%b perr=%b exp 0/0/0", irv, drv, perr); end
    tick();
    mv = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (perr !== 1'b1) begin errs++; $display("FAIL proto_sticky[%0d] perr=%b exp 1", i, perr); end
      tick();
    end
    dr = 1; mg = 1;
    tick();
    tick();
    dr = 0; mg = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL proto_busy busy=%b exp 1", busy); end
    rst = 1;
    #1;
    checks++; if (busy !== 1'b0 || perr !== 1'b0 || mreq !== 1'b0) begin errs++; $display("FAIL async_reset busy=%b perr=%b req=%b exp 0/0/0", busy, perr, mreq); end
    tick();
    rst = 0;
    mv = 1;
    @(negedge clk);
    checks++; if (irv !== 1'b0 || drv !== 1'b0) begin errs++; $display("FAIL late_resp irv=%b drv=%b exp 0/0", irv, drv); end
    tick();
    mv = 0;
    @(negedge clk);
    checks++; if (perr !== 1'b1) begin errs++; $display("FAIL late_perr perr=%b exp 1", perr); end
    tick();
    idle();
  endtask

  task automatic test_random;
    logic q[$];
    logic last, lk, ls, hold_i, hold_d, w, ereq, eig, edg, pop, eirv, edrv;
    logic [31:0] eaddr;
    pulse_reset();
    last = 0; lk = 0; ls = 0; hold_i = 0; hold_d = 0;
    for (int n = 0; n < 400; n++) begin
      if (!hold_i) begin ir = 1'($urandom); ia = $urandom; end
      if (!hold_d) begin dr = 1'($urandom); da = $urandom; dwe = 1'($urandom); dbe = 4'($urandom); dwd = $urandom; end
      mg = 1'($urandom);
      mv = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      me = 1'($urandom); mrd = $urandom;
      w = lk ? ls : (ir && dr) ? !last : dr;
      ereq = (q.size() < 2 || mv) && (w ? dr : ir);
      eig = ereq && mg && !w;
      edg = ereq && mg && w;
      pop = mv && q.size() > 0;
      eirv = pop && q[0] == 1'b0;
      edrv = pop && q[0] == 1'b1;
      eaddr = w ? da : ia;
      @(negedge clk);
      checks++; if (mreq !== ereq || igt !== eig || dgt !== edg) begin errs++; $display("FAIL rnd_gnt[%0d] req=%b igt=%b dgt=%b exp %b/%b/%b", n, mreq, igt, dgt, ereq, eig, edg); end
      checks++; if (irv !== eirv || drv !== edrv || ierr !== (eirv && me) || derr !== (edrv && me)) begin errs++; $display("FAIL rnd_resp[%0d] irv=%b drv=%b ierr=%b derr=%b exp %b/%b/%b/%b", n, irv, drv, ierr, derr, eirv, edrv, eirv && me, edrv && me); end
      checks++; if (ereq && (maddr !== eaddr || mwe !== (w && dwe) || mbe !== (w ? dbe : 4'hF))) begin errs++; $display("FAIL rnd_addr[%0d] addr=%h we=%b be=%h exp %h/%b/%h", n, maddr, mwe, mbe, eaddr, w && dwe, w ? dbe : 4'hF); end
      checks++; if (busy !== (q.size() == 2) || perr !== 1'b0) begin errs++; $display("FAIL rnd_busy[%0d] busy=%b perr=%b exp %b/0", n, busy, perr, q.size() == 2); end
      if (pop) void'(q.pop_front());
      if (ereq && mg) begin q.push_back(w); last = w; end
      lk = ereq && !mg;
      ls = w;
      hold_i = ir && !eig;
      hold_d = dr && !edg;
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_instr_single();
    test_rr_alternate();
    test_lock();
    test_capacity();
    test_err_routing();
    test_proto_err_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
